// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath/memory.
// The master is the controller; the slave is the datapath side that supplies the IR and flags.
interface multicycle_control_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  immControl;
  logic [3:0]  aluControl;
  logic [1:0]  aluSrcA;
  logic [1:0]  aluSrcB;
  logic [1:0]  resultSrc;
  logic        adrSrc;
  logic        memReq;
  logic        memWrite;
  logic        irWrite;
  logic        pcWrite;
  logic        regWrite;
  logic        trap;
  logic [31:0] instret;

  modport master (
    input  instr, zero, mem_ready,
    output immControl, aluControl, aluSrcA, aluSrcB, resultSrc, adrSrc,
           memReq, memWrite, irWrite, pcWrite, regWrite, trap, instret
  );

  modport slave (
    output instr, zero, mem_ready,
    input  immControl, aluControl, aluSrcA, aluSrcB, resultSrc, adrSrc,
           memReq, memWrite, irWrite, pcWrite, regWrite, trap, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/memory/
// write-back over the shared datapath, counts retired instructions and halts on illegal encodings.
module multicycle_control (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_if.master       bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2, S_LUI, S_AUIPC, S_TRAP
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R    = 7'b0110011,
                         OP_I    = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;

  // Shared R/I arithmetic decode; alt selects SUB/SRA where the encoding allows it.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;

  logic [2:0]  imm_sel;
  logic [3:0]  alu_ctl;
  logic [1:0]  src_a, src_b, res_sel;
  logic        adr_sel, mem_req, mem_write, ir_write, pc_write, reg_write;
  logic        retire, taken, branch_bad;

  assign opcode   = bus.instr[6:0];
  assign funct3   = bus.instr[14:12];
  assign funct7_5 = bus.instr[30];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    imm_sel    = 3'd0;
    alu_ctl    = ALU_ADD;
    src_a      = 2'd0;
    src_b      = 2'd0;
    res_sel    = 2'd0;
    adr_sel    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    taken      = 1'b0;
    branch_bad = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        src_b   = 2'd2;
        res_sel = 2'd2;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // oldPC + B-immediate lands in aluOut, ready for a taken branch.
        src_a   = 2'd1;
        src_b   = 2'd1;
        imm_sel = 3'd2;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a   = 2'd2;
        src_b   = 2'd1;
        imm_sel = opcode[5] ? 3'd1 : 3'd0;
        state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_sel = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        res_sel   = 2'd1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_sel   = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        src_a   = 2'd2;
        alu_ctl = alu_op(funct3, funct7_5);
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        // Only SRAI borrows funct7[5]; ADDI never becomes SUB.
        src_a   = 2'd2;
        src_b   = 2'd1;
        alu_ctl = alu_op(funct3, funct7_5 && (funct3 == 3'b101));
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        src_a = 2'd2;
        case (funct3)
          3'b000:  begin alu_ctl = ALU_SUB;  taken = bus.zero;  end
          3'b001:  begin alu_ctl = ALU_SUB;  taken = !bus.zero; end
          3'b100:  begin alu_ctl = ALU_SLT;  taken = !bus.zero; end
          3'b101:  begin alu_ctl = ALU_SLT;  taken = bus.zero;  end
          3'b110:  begin alu_ctl = ALU_SLTU; taken = !bus.zero; end
          3'b111:  begin alu_ctl = ALU_SLTU; taken = bus.zero;  end
          default: branch_bad = 1'b1;
        endcase
        if (branch_bad) begin
          state_d = S_TRAP;
        end else begin
          pc_write = taken;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_JAL: begin
        pc_write = 1'b1;
        src_a    = 2'd1;
        src_b    = 2'd2;
        state_d  = S_ALUWB;
      end
      S_JALR: begin
        src_a   = 2'd2;
        src_b   = 2'd1;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        pc_write = 1'b1;
        src_a    = 2'd1;
        src_b    = 2'd2;
        state_d  = S_ALUWB;
      end
      S_LUI: begin
        src_a   = 2'd3;
        src_b   = 2'd1;
        imm_sel = 3'd3;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        src_a   = 2'd1;
        src_b   = 2'd1;
        imm_sel = 3'd3;
        state_d = S_ALUWB;
      end
      default: state_d = S_TRAP;
    endcase

    // Reset kills any in-flight access at once rather than waiting for the clock.
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end

    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign bus.immControl = imm_sel;
  assign bus.aluControl = alu_ctl;
  assign bus.aluSrcA    = src_a;
  assign bus.aluSrcB    = src_b;
  assign bus.resultSrc  = res_sel;
  assign bus.adrSrc     = adr_sel;
  assign bus.memReq     = mem_req;
  assign bus.memWrite   = mem_write;
  assign bus.irWrite    = ir_write;
  assign bus.pcWrite    = pc_write;
  assign bus.regWrite   = reg_write;
  assign bus.trap       = (state_q == S_TRAP);
  assign bus.instret    = instret_q;

endmodule
